// File: rtl/hilo_mdu_if.sv
// rtl/hilo_mdu_if.sv - issue/result bundle between the execute stage and the HI/LO multiply-divide unit
// Signals:
//   start - issue strobe, samples op/srca/srcb
//   op    - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no effect
//   srca  - rs operand (multiplicand/dividend, MTHI/MTLO source)
//   srcb  - rt operand (multiplier/divisor)
//   flush - aborts any in-flight operation
//   busy  - registered stall request
//   hi/lo - architectural HI/LO registers
interface hilo_mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, srca, srcb, flush,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb, flush,
        output busy, hi, lo
    );
endinterface

// File: rtl/hilo_mdu.sv
// rtl/hilo_mdu.sv - MIPS HI/LO multiply/divide unit with one-cycle multiply and 32-step restoring divider
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - hilo_mdu_if slave: start/op/srca/srcb/flush in, busy/hi/lo out
module hilo_mdu (
    input  logic       clk,
    input  logic       rst,
    hilo_mdu_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t      state;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_signed;

    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic [5:0]  cnt;
    logic        neg_quo;
    logic        neg_rem;

    logic        div_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        ext_a;
    logic        ext_b;
    logic [63:0] product;
    logic [33:0] rem_sh;
    logic [33:0] trial;
    logic        keep;

    // Magnitudes are taken as unsigned 32-bit values: negating 0x80000000
    // yields 0x80000000, which read unsigned is exactly 2^31.
    always_comb begin
        div_signed = (bus.op == 3'd2);
        a_mag      = (div_signed && bus.srca[31]) ? (32'd0 - bus.srca) : bus.srca;
        b_mag      = (div_signed && bus.srcb[31]) ? (32'd0 - bus.srcb) : bus.srcb;
    end

    // Low 64 bits of the product of the 64-bit extended operands equal the
    // signed or unsigned 32x32 product depending on the extension used.
    always_comb begin
        ext_a   = mul_signed & mul_a[31];
        ext_b   = mul_signed & mul_b[31];
        product = {{32{ext_a}}, mul_a} * {{32{ext_b}}, mul_b};
    end

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor,
    // keep the difference when it did not go negative.
    always_comb begin
        rem_sh = {rem, quo[31]};
        trial  = rem_sh - {2'b00, divisor};
        keep   = ~trial[33];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            mul_a      <= 32'd0;
            mul_b      <= 32'd0;
            mul_signed <= 1'b0;
            rem        <= 33'd0;
            quo        <= 32'd0;
            divisor    <= 32'd0;
            cnt        <= 6'd0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        case (bus.op)
                            3'd0, 3'd1: begin
                                mul_a      <= bus.srca;
                                mul_b      <= bus.srcb;
                                mul_signed <= (bus.op == 3'd0);
                                state      <= S_MUL;
                                busy_q     <= 1'b1;
                            end
                            3'd2, 3'd3: begin
                                rem     <= 33'd0;
                                quo     <= a_mag;
                                divisor <= b_mag;
                                cnt     <= 6'd0;
                                neg_quo <= div_signed & (bus.srca[31] ^ bus.srcb[31]);
                                neg_rem <= div_signed & bus.srca[31];
                                state   <= S_DIV;
                                busy_q  <= 1'b1;
                            end
                            3'd4:    hi_q <= bus.srca;
                            3'd5:    lo_q <= bus.srca;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    if (!bus.flush) begin
                        {hi_q, lo_q} <= product;
                    end
                end
                S_DIV: begin
                    if (bus.flush) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        rem <= keep ? trial[32:0] : rem_sh[32:0];
                        quo <= {quo[30:0], keep};
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    if (!bus.flush) begin
                        lo_q <= neg_quo ? (32'd0 - quo) : quo;
                        hi_q <= neg_rem ? (32'd0 - rem[31:0]) : rem[31:0];
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_mdu.sv
// tb/tb_hilo_mdu.sv - scoreboard bench for hilo_mdu
module tb_hilo_mdu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_mdu_if bus ();
    hilo_mdu dut (.clk(clk), .rst(rst), .bus(bus));

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] arch;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; return p; end
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            3'd4: return {a, cur[31:0]};
            3'd5: return {cur[63:32], a};
            default: return cur;
        endcase
    endfunction

    // Pulses start for one cycle; returns #1 into cycle 1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.srca = a; bus.srcb = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Counts busy cycles from cycle 1; -1 if busy never drops.
    task automatic wait_idle(output int n);
        n = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        arch = model(op, a, b, arch);
        exp_q.push_back(arch);
        issue(op, a, b);
        wait_idle(n);
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op = 3'd0; bus.srca = 32'd0; bus.srcb = 32'd0; bus.flush = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        arch = 64'd0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    endtask

    task automatic test_mult();
        logic [2:0]  ops[4] = '{3'd0, 3'd1, 3'd0, 3'd1};
        logic [31:0] as[4]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
        logic [31:0] bs[4]  = '{32'd5, 32'hFFFFFFFF, 32'h80000000, 32'h9ABCDEF0};
        logic [63:0] e;
        int n;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], n);
            e = exp_q.pop_front();
            total++; if (n !== 1) begin bad++; $display("FAIL mult_busy[%0d]: got %0d want 1", i, n); end
            total++; if (bus.hi !== e[63:32]) begin bad++; $display("FAIL mult_hi[%0d]: got %h want %h", i, bus.hi, e[63:32]); end
            total++; if (bus.lo !== e[31:0]) begin bad++; $display("FAIL mult_lo[%0d]: got %h want %h", i, bus.lo, e[31:0]); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops[8] = '{3'd2, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd2, 3'd3};
        logic [31:0] as[8]  = '{32'hFFFFFFF9, 32'h80000000, 32'd100, 32'hFFFFFF9C,
                                32'hFFFFFFFF, 32'd7, 32'h0, 32'h0};
        logic [31:0] bs[8]  = '{32'd2, 32'hFFFFFFFF, 32'd0, 32'd0,
                                32'd7, 32'hFFFFFFFE, 32'h0, 32'h0};
        logic [63:0] e;
        int n;
        as[6] = $urandom; bs[6] = $urandom | 32'h1;
        as[7] = $urandom; bs[7] = $urandom_range(1, 65535);
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], n);
            e = exp_q.pop_front();
            total++; if (n !== 33) begin bad++; $display("FAIL div_busy[%0d]: got %0d want 33", i, n); end
            total++; if (bus.hi !== e[63:32]) begin bad++; $display("FAIL div_hi[%0d]: got %h want %h", i, bus.hi, e[63:32]); end
            total++; if (bus.lo !== e[31:0]) begin bad++; $display("FAIL div_lo[%0d]: got %h want %h", i, bus.lo, e[31:0]); end
        end
    endtask

    task automatic test_mthilo();
        logic [2:0]  ops[3] = '{3'd4, 3'd5, 3'd6};
        logic [31:0] as[3]  = '{32'h11111111, 32'h22222222, 32'hDEADBEEF};
        logic [63:0] e;
        int n;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], 32'h5, n);
            e = exp_q.pop_front();
            total++; if (n !== 0) begin bad++; $display("FAIL mt_busy[%0d]: got %0d want 0", i, n); end
            total++; if (bus.hi !== e[63:32]) begin bad++; $display("FAIL mt_hi[%0d]: got %h want %h", i, bus.hi, e[63:32]); end
            total++; if (bus.lo !== e[31:0]) begin bad++; $display("FAIL mt_lo[%0d]: got %h want %h", i, bus.lo, e[31:0]); end
        end
    endtask

    task automatic test_flush();
        // flush at divide iteration 10 (cycle 11)
        issue(3'd3, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_div_busy: got %b want 0", bus.busy); end
        total++; if ({bus.hi, bus.lo} !== arch) begin bad++; $display("FAIL flush_div_hilo: got %h want %h", {bus.hi, bus.lo}, arch); end
        // flush in the FIX cycle (cycle 33)
        issue(3'd3, 32'd1000, 32'd7);
        repeat (32) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL flush_fix_inflight: got %b want 1", bus.busy); end
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_fix_busy: got %b want 0", bus.busy); end
        total++; if ({bus.hi, bus.lo} !== arch) begin bad++; $display("FAIL flush_fix_hilo: got %h want %h", {bus.hi, bus.lo}, arch); end
        // flush concurrent with start in IDLE
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'd0; bus.srca = 32'd3; bus.srcb = 32'd3; bus.flush = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        total++; if ({bus.hi, bus.lo} !== arch) begin bad++; $display("FAIL flush_start_hilo: got %h want %h", {bus.hi, bus.lo}, arch); end
    endtask

    task automatic test_ignored_mtlo();
        logic [63:0] e;
        int n;
        arch = model(3'd3, 32'd500, 32'd3, arch);
        exp_q.push_back(arch);
        issue(3'd3, 32'd500, 32'd3);
        repeat (4) @(posedge clk);
        #1 bus.start = 1'b1; bus.op = 3'd5; bus.srca = 32'hDEADBEEF;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_idle(n);
        e = exp_q.pop_front();
        total++; if (n !== 28) begin bad++; $display("FAIL busy_mtlo_cycles: got %0d want 28", n); end
        total++; if (bus.lo !== e[31:0]) begin bad++; $display("FAIL busy_mtlo_lo: got %h want %h", bus.lo, e[31:0]); end
        total++; if (bus.hi !== e[63:32]) begin bad++; $display("FAIL busy_mtlo_hi: got %h want %h", bus.hi, e[63:32]); end
        @(negedge clk);
        total++; if (bus.lo !== e[31:0]) begin bad++; $display("FAIL busy_mtlo_late: got %h want %h", bus.lo, e[31:0]); end
    endtask

    task automatic test_rst_mid();
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        arch = 64'd0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL rst_mid_hi: got %h want 0", bus.hi); end
        total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL rst_mid_lo: got %h want 0", bus.lo); end
        repeat (40) @(negedge clk);
        total++; if ({bus.hi, bus.lo} !== 64'd0) begin bad++; $display("FAIL rst_mid_late: got %h want 0", {bus.hi, bus.lo}); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        int n;
        arch = model(3'd0, 32'd7, 32'hFFFFFFFA, arch);
        exp_q.push_back(arch);
        issue(3'd0, 32'd7, 32'hFFFFFFFA);
        @(posedge clk); #1;
        arch = model(3'd3, 32'd1000, 32'd9, arch);
        exp_q.push_back(arch);
        bus.start = 1'b1; bus.op = 3'd3; bus.srca = 32'd1000; bus.srcb = 32'd9;
        @(negedge clk);
        e = exp_q.pop_front();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_mul_busy: got %b want 0", bus.busy); end
        total++; if ({bus.hi, bus.lo} !== e) begin bad++; $display("FAIL b2b_mul_hilo: got %h want %h", {bus.hi, bus.lo}, e); end
        @(posedge clk); #1 bus.start = 1'b0;
        wait_idle(n);
        e = exp_q.pop_front();
        total++; if (n !== 33) begin bad++; $display("FAIL b2b_div_busy: got %0d want 33", n); end
        total++; if ({bus.hi, bus.lo} !== e) begin bad++; $display("FAIL b2b_div_hilo: got %h want %h", {bus.hi, bus.lo}, e); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthilo();
        test_flush();
        test_ignored_mtlo();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
